mul_seq_ctrl: RTL
=================

// Module: mul_seq_ctrl
// PURPOSE
//  Iterative OPW x OPW unsigned multiplier built around one shared 4x4 combinational array multiplier core.
//  Splits each operand into 4-bit nibbles and sequences the core over all nibble pairs, one pair per cycle.
//  Shifts and accumulates each partial product. Valid/ready handshake on both sides.
//  Trades latency for area wherever a wide product is needed only occasionally.
// PARAMETERS
//  OPW      8  operand width; legal values 4, 8, 12, 16; NP = OPW/4 nibbles per operand
//  PIPE_PP  0  1 = register the core product before accumulation (+1 cycle latency)
// PORTS
//  clk       in   1      single clock, all state on rising edge
//  rst_n     in   1      reset, asynchronous, active-low
//  in_valid  in   1      operand pair offered
//  in_ready  out  1      controller can accept operands
//  in_a      in   OPW    multiplicand, unsigned
//  in_b      in   OPW    multiplier, unsigned
//  out_valid out  1      out_prod holds a finished product
//  out_ready in   1      consumer takes the product
//  out_prod  out  2*OPW  product in_a*in_b, exact, no truncation
//  busy      out  1      high from accept until the result handshake completes
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state=IDLE, acc=0, out_prod=0, out_valid=0, busy=0, pass index=0.
//    in_ready is forced to 0 while rst_n is low; it is 1 from the first edge after release.
//  FSM: IDLE -> RUN -> [PP_DRAIN if PIPE_PP=1] -> DONE -> IDLE.
//  IDLE: in_ready=1. When in_valid&&in_ready on an edge: latch in_a and in_b, clear acc, go to RUN.
//  RUN: one pass per cycle; pass k=j*NP+i; the core gets a[4i+3:4i] and b[4j+3:4j].
//    acc += core_p << 4*(i+j). acc is 2*OPW bits wide; no overflow is possible.
//    After the last pass: go to DONE (PIPE_PP=0) or PP_DRAIN (PIPE_PP=1).
//  PP_DRAIN: accumulate the final registered product, then go to DONE.
//  DONE: out_valid=1; out_prod=acc, held stable until out_valid&&out_ready; then go to IDLE.
//  Latency: out_valid rises NP*NP edges after the accepting edge (4 for OPW=8); add 1 edge when PIPE_PP=1.
//  in_ready=0 in RUN, PP_DRAIN and DONE. There is no overlap of operations.
//    After a result handshake there is always 1 idle cycle before the next accept.
//  in_valid while not ready: ignored; operands are sampled only on the accept edge.
//  Changes to in_a or in_b during RUN have no effect.
//  out_prod keeps the last result in IDLE until the next accept clears acc.
//  Reset mid-operation: the partial acc is discarded; the next operation after release is unaffected.
// CONFIGURATION
//  MUL_SEQ_ZERO_SKIP_EN defined:
//    Pass scheduler jumps straight to the next (i,j) where both nibbles are nonzero.
//    If no such pair remains, go directly to DONE (or PP_DRAIN).
//    Latency = max(1, N_nonzero_pairs) edges (+1 when PIPE_PP=1).
//    in_a==0 or in_b==0 gives out_prod=0 after 1 edge.
//  Undefined: all NP*NP passes always execute; latency is fixed as above.
// STRUCTURE
//  mul_seq_pkg:
//    state enum typedef {IDLE,RUN,PP_DRAIN,DONE}
//    NIB_W=4
//    function npass(OPW) returning (OPW/4)**2
//    function shift amount 4*(i+j)
//  Sub-module mul4_core: combinational 4x4 array multiplier (AND partial products, HA/FA rows), p[7:0].
//    Exactly one instance in this block.
//  In this block: FSM, i/j counters, operand registers, nibble muxes, optional pipeline reg, accumulator.
// TESTING
//  1 OPW=8: a=0xFF, b=0xFF -> out_prod=0xFE01; out_valid exactly 4 edges after accept (5 with PIPE_PP=1).
//  2 a=0x12, b=0x34; out_ready low 10 cycles -> out_prod=0x03A8 held stable, in_ready=0.
//    Competing in_valid during this time is not accepted.
//  3 a=0x00, b=0x37 -> 0x0000. Without the macro: 4 edges. With MUL_SEQ_ZERO_SKIP_EN: 1 edge.
//    Also a=0x30, b=0x05 -> 0x00F0 after 1 edge.
//  4 rst_n low during pass 2 -> out_valid=0 and in_ready=0 immediately.
//    After release, a=0x0F, b=0x10 -> 0x00F0 (no stale acc).
//  5 Random 10k ops vs a*b model, OPW in {8,16} x PIPE_PP in {0,1} x macro on/off.
//    Check latency and the 1-cycle idle gap after each result handshake.

Source files
------------

// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequential nibble multiplier (mul_seq_ctrl).
package mul_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    PP_DRAIN = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam int NIB_W = 4;

  // Number of nibble-pair passes for an operand width
  function automatic int npass(input int opw);
    return (opw / NIB_W) * (opw / NIB_W);
  endfunction

  // Left shift applied to the partial product of nibble pair (i,j)
  function automatic int unsigned shamt(input int unsigned i, input int unsigned j);
    return NIB_W * (i + j);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_mul4_core.sv
// Combinational 4x4 unsigned array multiplier: AND partial-product rows
// reduced by one ripple full-adder chain per row.
module mul4_core (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);

  // pp[r][c] = a[c] & b[r]
  logic [3:0][3:0] pp;

  for (genvar gi = 0; gi < 4; gi++) begin : g_pp_row
    for (genvar gj = 0; gj < 4; gj++) begin : g_pp_bit
      assign pp[gi][gj] = a_i[gj] & b_i[gi];
    end
  end

  // Add each AND row into the upper bits of the running sum; the low bit retires into p_o
  always_comb begin
    logic [4:0] s;
    logic       c;
    logic       x;
    s      = {1'b0, pp[0]};
    c      = 1'b0;
    x      = 1'b0;
    p_o    = '0;
    p_o[0] = s[0];
    for (int r = 1; r < 4; r++) begin
      c = 1'b0;
      for (int k = 0; k < 4; k++) begin
        x    = s[k+1];
        s[k] = x ^ pp[r][k] ^ c;
        c    = (x & pp[r][k]) | (c & (x ^ pp[r][k]));
      end
      s[4]   = c;
      p_o[r] = s[0];
    end
    p_o[7:4] = s[4:1];
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Iterative OPW x OPW unsigned multiplier that time-shares one 4x4 core over
// all nibble pairs, one pair per cycle, with valid/ready on both sides.
// Optional feature macro: MUL_SEQ_ZERO_SKIP_EN (skip pairs with a zero nibble).
module mul_seq_ctrl
  import mul_seq_pkg::*;
#(
  parameter int OPW     = 8,
  parameter int PIPE_PP = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*OPW-1:0] out_prod,
  output logic             busy
);

  localparam int NP    = OPW / NIB_W;
  localparam int NPASS = npass(OPW);
  localparam int PW    = 2 * OPW;
  localparam int IW    = (NP > 1) ? $clog2(NP) : 1;
  localparam int SW    = $clog2(PW);

  state_e          state_q;
  logic [OPW-1:0]  a_q, b_q;
  logic [PW-1:0]   acc_q;
  logic [IW-1:0]   i_q, j_q;
  logic            pass_vld_q;  // current (i,j) is a real pass (low only for an all-skip op)
  logic            in_ready_q, out_valid_q, busy_q;

  logic [NPASS-1:0] run_mask, acc_mask;
  logic             first_found, nxt_found;
  logic [IW-1:0]    first_i, first_j, nxt_i, nxt_j;
  int               cur_k;

  logic [NIB_W-1:0] a_nib, b_nib;
  logic [7:0]       core_p;
  logic [SW-1:0]    cur_sh;
  logic             add_en;
  logic [PW-1:0]    add_term;

`ifdef MUL_SEQ_ZERO_SKIP_EN
  // Only pairs whose nibbles are both nonzero contribute; mark them for the scheduler
  always_comb begin
    run_mask = '0;
    acc_mask = '0;
    for (int jj = 0; jj < NP; jj++) begin
      for (int ii = 0; ii < NP; ii++) begin
        run_mask[jj*NP+ii] = (a_q[ii*NIB_W +: NIB_W] != '0) && (b_q[jj*NIB_W +: NIB_W] != '0);
        acc_mask[jj*NP+ii] = (in_a[ii*NIB_W +: NIB_W] != '0) && (in_b[jj*NIB_W +: NIB_W] != '0);
      end
    end
  end
`else
  assign run_mask = '1;
  assign acc_mask = '1;
`endif

  // Pass scheduler: first pending pair for a new operation, next pending pair after the current one
  always_comb begin
    cur_k       = int'(j_q) * NP + int'(i_q);
    first_found = 1'b0;
    first_i     = '0;
    first_j     = '0;
    nxt_found   = 1'b0;
    nxt_i       = '0;
    nxt_j       = '0;
    for (int kk = NPASS - 1; kk >= 0; kk--) begin
      if (acc_mask[kk]) begin
        first_found = 1'b1;
        first_i     = IW'(kk % NP);
        first_j     = IW'(kk / NP);
      end
      if (run_mask[kk] && (kk > cur_k)) begin
        nxt_found = 1'b1;
        nxt_i     = IW'(kk % NP);
        nxt_j     = IW'(kk / NP);
      end
    end
  end

  assign a_nib  = a_q[NIB_W*int'(i_q) +: NIB_W];
  assign b_nib  = b_q[NIB_W*int'(j_q) +: NIB_W];
  assign cur_sh = SW'(shamt(int'(i_q), int'(j_q)));

  mul4_core u_core (
    .a_i (a_nib),
    .b_i (b_nib),
    .p_o (core_p)
  );

  if (PIPE_PP != 0) begin : g_pipe
    logic [7:0]    pp_q;
    logic [SW-1:0] sh_q;
    logic          pp_vld_q;

    // Register the core product and its shift so the adder sees a full cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pp_q     <= '0;
        sh_q     <= '0;
        pp_vld_q <= 1'b0;
      end else begin
        pp_q     <= core_p;
        sh_q     <= cur_sh;
        pp_vld_q <= (state_q == RUN) && pass_vld_q;
      end
    end

    assign add_en   = pp_vld_q;
    assign add_term = PW'(pp_q) << sh_q;
  end else begin : g_direct
    assign add_en   = (state_q == RUN) && pass_vld_q;
    assign add_term = PW'(core_p) << cur_sh;
  end

  // Control FSM with operand/accumulator registers and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      pass_vld_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= in_a;
            b_q        <= in_b;
            acc_q      <= '0;
            i_q        <= first_i;
            j_q        <= first_j;
            pass_vld_q <= first_found;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          if (add_en) acc_q <= acc_q + add_term;
          if (pass_vld_q && nxt_found) begin
            i_q <= nxt_i;
            j_q <= nxt_j;
          end else begin
            i_q        <= '0;
            j_q        <= '0;
            pass_vld_q <= 1'b0;
            if (PIPE_PP != 0) begin
              state_q <= PP_DRAIN;
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        PP_DRAIN: begin
          if (add_en) acc_q <= acc_q + add_term;
          state_q     <= DONE;
          out_valid_q <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_prod  = acc_q;
  assign busy      = busy_q;

endmodule
